i2s_rx_ctrl: RTL

I2S_RX_CTRL -- requirements
Module: i2s_rx_ctrl

---
 rtl/i2s_rx_ctrl_if.sv | 24 ++
 rtl/i2s_rx_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_ctrl_if.sv
// Sample stream handshake between the I2S receiver and its consumer.
//   sample_data  : head-of-buffer word
//   sample_right : channel tag of sample_data (1 = right)
//   sample_valid : buffer not empty
//   sample_ready : consumer accepts the word this cycle
// master = receiver side, slave = consumer side.
interface i2s_rx_ctrl_if #(
  parameter int SLOT_BITS = 16
);
  logic [SLOT_BITS-1:0] sample_data;
  logic                 sample_right;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (
    output sample_data, sample_right, sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data, sample_right, sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_rx_ctrl.sv
// I2S receive controller (clock master).
// Generates AUD_BCK / AUD_LRCK from AUD_XCK, shifts AUD_DATA in on the
// AUD_XCK cycle in which BCK is driven high, and buffers finished words in
// a 2-entry FIFO exposed through the sample handshake interface.
// Ports:
//   AUD_XCK      : sole clock
//   reset        : synchronous active-high reset
//   enable       : run request (IDLE->RUN, RUN->STOP when low)
//   ch_mask      : per-channel capture enable, bit0 left, bit1 right
//   AUD_DATA     : serial codec data
//   AUD_BCK      : generated bit clock (registered)
//   AUD_LRCK     : generated word clock (registered), 0 = left
//   smp          : sample stream (data / right tag / valid / ready)
//   overrun      : sticky, a finished word was dropped on a full buffer
//   overrun_clr  : clears overrun (a simultaneous set wins)
//   busy         : state is not IDLE
module i2s_rx_ctrl #(
  parameter int BCK_HALF   = 6,
  parameter int SLOT_BITS  = 16,
  parameter int DATA_DELAY = 1
) (
  input  logic                AUD_XCK,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          ch_mask,
  input  logic                AUD_DATA,
  output logic                AUD_BCK,
  output logic                AUD_LRCK,
  i2s_rx_ctrl_if.master       smp,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic                busy
);

  localparam int DW = $clog2(BCK_HALF);
  localparam int BW = $clog2(SLOT_BITS);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t state_q;
  logic   busy_q;

  // clock generation
  logic [DW-1:0] div_q, div_d;
  logic          bck_q, bck_d;
  logic          lrck_q, lrck_d;
  logic [BW-1:0] bit_q, bit_d;

  // word assembly
  logic [SLOT_BITS-1:0] sh_q, sh_d;
  logic                 act_q, act_d;   // a word has had its MSB sampled
  logic                 tag_q, tag_d;   // slot of that MSB
  logic                 keep_q, keep_d; // channel enabled at MSB time

  // 2-entry buffer
  logic [SLOT_BITS-1:0] mem_q [2];
  logic [1:0]           rtag_q;
  logic                 wp_q, rp_q;
  logic [1:0]           cnt_q;
  logic                 ovr_q;

  logic                 running, tc, rise, fall, done, push, right_done, to_idle;
  logic                 valid, pop, full, wr, drop;
  logic [SLOT_BITS-1:0] word;
  int                   widx;

  always_comb begin
    running    = (state_q != IDLE);
    tc         = running && (div_q == DW'(BCK_HALF-1));
    rise       = tc && !bck_q;
    fall       = tc && bck_q;
    // position of the bit sampled at this rise within its word (0 = MSB);
    // DATA_DELAY shifts the word so the LSB may land in the next slot
    widx       = (int'(bit_q) + SLOT_BITS - DATA_DELAY) % SLOT_BITS;
    word       = {sh_q[SLOT_BITS-2:0], AUD_DATA};
    done       = rise && act_q && (widx == SLOT_BITS-1);
    push       = done && keep_q;
    right_done = done && tag_q;
    to_idle    = (state_q == STOP) && right_done;

    valid      = (cnt_q != 2'd0);
    pop        = valid && smp.sample_ready;
    full       = (cnt_q == 2'd2);
    wr         = push && (!full || pop);
    drop       = push && full && !pop;
  end

  always_ff @(posedge AUD_XCK) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (enable) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: if (!enable) state_q <= STOP;
        STOP: if (right_done) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    div_d  = div_q;
    bck_d  = bck_q;
    lrck_d = lrck_q;
    bit_d  = bit_q;
    // leaving STOP zeroes the clocks on the same edge the last word lands
    if (!running || to_idle) begin
      div_d  = '0;
      bck_d  = 1'b0;
      lrck_d = 1'b0;
      bit_d  = '0;
    end else begin
      div_d = tc ? '0 : div_q + 1'b1;
      if (tc) bck_d = !bck_q;
      if (fall) begin
        if (bit_q == BW'(SLOT_BITS-1)) begin
          bit_d  = '0;
          lrck_d = !lrck_q;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sh_d   = sh_q;
    act_d  = act_q;
    tag_d  = tag_q;
    keep_d = keep_q;
    if (!running) begin
      act_d = 1'b0;
    end else if (rise) begin
      // stale upper bits are shifted out by the time the LSB arrives
      sh_d = word;
      if (widx == 0) begin
        act_d  = 1'b1;
        tag_d  = lrck_q;
        keep_d = ch_mask[lrck_q];
      end else if (widx == SLOT_BITS-1) begin
        act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge AUD_XCK) begin
    if (reset) begin
      div_q  <= '0;
      bck_q  <= 1'b0;
      lrck_q <= 1'b0;
      bit_q  <= '0;
      sh_q   <= '0;
      act_q  <= 1'b0;
      tag_q  <= 1'b0;
      keep_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bck_q  <= bck_d;
      lrck_q <= lrck_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      act_q  <= act_d;
      tag_q  <= tag_d;
      keep_q <= keep_d;
    end
  end

  // buffer: a push onto a full buffer is accepted only alongside a pop
  always_ff @(posedge AUD_XCK) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rtag_q <= '0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      cnt_q  <= 2'd0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wp_q]  <= word;
        rtag_q[wp_q] <= tag_q;
        wp_q         <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop)             ovr_q <= 1'b1;
      else if (overrun_clr) ovr_q <= 1'b0;
    end
  end

  assign AUD_BCK          = bck_q;
  assign AUD_LRCK         = lrck_q;
  assign busy             = busy_q;
  assign overrun          = ovr_q;
  assign smp.sample_data  = mem_q[rp_q];
  assign smp.sample_right = rtag_q[rp_q];
  assign smp.sample_valid = valid;

endmodule
